// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are active-high, bit0=a .. bit6=g.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = 8;
    localparam int SMP_W      = NUM_DIGITS + 7;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seg7_state_e;

    // Entry i is the lit-segment pattern for hex digit i.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        return SEG_PAT[d];
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low segment pattern to hex nibble decode.
// valid_o is low for any pattern outside the 16-entry table.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] hex_o,
    output logic       valid_o
);

    logic [6:0] seg_lit;

    assign seg_lit = ~seg_n_i;

    always_comb begin
        hex_o   = 4'h0;
        valid_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_lit == seg_pat(4'(i))) begin
                hex_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed active-low 7-seg scan.
// Define SEG7_ERR_CNT_EN to add the saturating err_cnt output.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        err
`ifdef SEG7_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [CNT_W-1:0] STABLE_W = CNT_W'(STABLE_CYC);

    seg7_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SMP_W-1:0]            lat_q, lat_d;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;
    logic [15:0]                 bcd_q;
    logic                        fv_q;
    logic                        err_q, err_d;

    logic [SMP_W-1:0]            smp;
    logic                        sel;
    logic [1:0]                  dig_idx;
    logic                        same;
    logic                        cap;
    logic                        commit;
    logic [3:0]                  hex;
    logic                        hex_vld;

    assign smp    = {an_in, seg_in};
    assign same   = (smp == lat_q);
    assign commit = &mask_q;

    // Exactly one low enable is a selection; anything else is idle.
    always_comb begin
        sel     = 1'b1;
        dig_idx = 2'd0;
        unique case (an_in)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: sel     = 1'b0;
        endcase
    end

    seg7_to_hex u_dec (
        .seg_n_i (seg_in),
        .hex_o   (hex),
        .valid_o (hex_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        cap     = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (sel) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    lat_d   = smp;
                end
            end
            ST_SETTLE: begin
                if (same) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (sel) begin
                    cnt_d = CNT_W'(1);
                    lat_d = smp;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    if (sel) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(1);
                        lat_d   = smp;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
        // Capture in the same cycle the run length reaches the threshold,
        // which also covers STABLE_CYC=1 straight out of WAIT or HOLD.
        if (state_d == ST_SETTLE && cnt_d == STABLE_W) begin
            cap     = 1'b1;
            state_d = ST_HOLD;
        end
    end

    // A full mask commits this cycle; a concurrent capture starts the next frame.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = commit ? '0 : mask_q;
        err_d    = 1'b0;
        if (cap) begin
            if (hex_vld) begin
                shadow_d[dig_idx] = hex;
                mask_d[dig_idx]   = 1'b1;
            end else begin
                mask_d[dig_idx]   = 1'b0;
                err_d             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            lat_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            bcd_q    <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            fv_q     <= commit;
            err_q    <= err_d;
            if (commit) begin
                bcd_q <= shadow_q;
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q;
    assign err         = err_q;

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] ecnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_q <= '0;
        end else if (err_d && ecnt_q != 8'hFF) begin
            ecnt_q <= ecnt_q + 8'd1;
        end
    end

    assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder against a behavioural model.
// Build with SEG7_ERR_CNT_EN defined to also exercise err_cnt.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        err;
`ifdef SEG7_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    seg7_scan_decoder #(.STABLE_CYC(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .err         (err)
`ifdef SEG7_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                             7'h39, 7'h5E, 7'h79, 7'h71};

    int n_chk = 0;
    int n_err = 0;
    int n_fv  = 0;
    int n_erp = 0;

    // Reference model: run length of identical selected samples.
    logic [10:0] m_prev;
    int          m_run;
    bit          m_done;
    logic [3:0]  m_sh [4];
    bit          m_mask [4];
    logic [15:0] m_bcd;
    bit          m_fv;
    bit          m_err;
    int          m_ecnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_idx(input logic [3:0] an);
        int zeros = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    function automatic int decode(input logic [6:0] seg_n);
        logic [6:0] lit = ~seg_n;
        for (int v = 0; v < 16; v++)
            if (PAT[v] == lit) return v;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '0;
        m_run  = 0;
        m_done = 0;
        m_bcd  = '0;
        m_fv   = 0;
        m_err  = 0;
        m_ecnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i]   = 4'h0;
            m_mask[i] = 0;
        end
    endtask

    task automatic model_step();
        int idx;
        int v;
        logic [10:0] s;
        if (rst) begin
            model_reset();
            return;
        end
        m_fv = 0;
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
            m_fv  = 1;
            m_bcd = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
        end
        idx = sel_idx(an_in);
        s = {an_in, seg_in};
        if (idx < 0) begin
            m_run  = 0;
            m_done = 0;
        end else if (m_run > 0 && s == m_prev) begin
            m_run++;
        end else begin
            m_run  = 1;
            m_done = 0;
        end
        m_prev = s;
        m_err = 0;
        if (idx >= 0 && !m_done && m_run == STABLE) begin
            m_done = 1;
            v = decode(seg_in);
            if (v >= 0) begin
                m_sh[idx]   = 4'(v);
                m_mask[idx] = 1;
            end else begin
                m_mask[idx] = 0;
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg,
                         input int n);
        for (int k = 0; k < n; k++) begin
            an_in  = an;
            seg_in = seg;
            @(posedge clk);
            model_step();
            #1;
            check("bcd_out", 32'(bcd_out), 32'(m_bcd));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("err", 32'(err), 32'(m_err));
`ifdef SEG7_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
            if (frame_valid) n_fv++;
            if (err) n_erp++;
        end
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic digit(input int d, input int v, input int n);
        drive(an_of(d), ~PAT[v], n);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        drive(4'hF, 7'h7F, 1);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] sg;
        model_reset();
        rst = 1'b1;
        drive(4'hF, 7'h7F, 2);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        n_erp = 0;
        digit(0, 2, 4);
        check("cap_d0_err", 32'(n_erp), 32'd0);

        n_fv = 0;
        for (int d = 0; d < 4; d++) digit(d, d + 1, 6);
        drive(4'hF, 7'h7F, 2);
        check("frame_cnt", 32'(n_fv), 32'd1);
        check("frame_val", 32'(bcd_out), 32'h4321);

        digit(1, 8, 2);
        drive(an_of(1), ~7'h7E, 1);
        digit(1, 8, 4);
        n_fv = 0;
        digit(0, 5, 5);
        digit(2, 6, 5);
        digit(3, 7, 5);
        drive(4'hF, 7'h7F, 2);
        check("glitch_cnt", 32'(n_fv), 32'd1);
        check("glitch_val", 32'(bcd_out), 32'h7685);

        n_fv = 0;
        n_erp = 0;
        drive(an_of(2), ~7'h01, 6);
        check("inv_err", 32'(n_erp), 32'd1);
        digit(0, 9, 5);
        digit(1, 10, 5);
        digit(3, 11, 5);
        drive(4'hF, 7'h7F, 3);
        check("inv_nofv", 32'(n_fv), 32'd0);
        check("inv_bcd", 32'(bcd_out), 32'h7685);

        n_erp = 0;
        drive(4'b1100, ~PAT[3], 10);
        check("multi_err", 32'(n_erp), 32'd0);

        pulse_rst();
        n_fv = 0;
        digit(0, 1, 5);
        digit(1, 2, 5);
        digit(2, 3, 5);
        pulse_rst();
        digit(3, 4, 5);
        drive(4'hF, 7'h7F, 3);
        check("rst_mid_fv", 32'(n_fv), 32'd0);
        check("rst_mid_bcd", 32'(bcd_out), 32'h0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 8) an = an_of(int'($urandom_range(0, 3)));
            else an = 4'($urandom);
            if ($urandom_range(0, 9) < 8) sg = ~PAT[$urandom_range(0, 15)];
            else sg = 7'($urandom);
            if ($urandom_range(0, 99) == 0) pulse_rst();
            drive(an, sg, int'($urandom_range(1, 7)));
        end

`ifdef SEG7_ERR_CNT_EN
        pulse_rst();
        for (int k = 0; k < 300; k++) drive(an_of(k % 2), ~7'h01, STABLE);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
